// File: rtl/comparador_serial_ctrl.sv
// Sequential unsigned magnitude comparator: a single 4-bit comparator is
// time-shared over the operand nibbles MSB-first, with early exit on the first difference.

module comparador_4_bits (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       g,
    output logic       l,
    output logic       e
);

    assign g = (a > b);
    assign l = (a < b);
    assign e = (a == b);

endmodule

module comparador_serial_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             G,
    output logic             L,
    output logic             E
);

    localparam int N     = WIDTH / 4;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             g_q, g_d;
    logic             l_q, l_d;
    logic             e_q, e_d;

    logic [3:0]       nib_a, nib_b;
    logic             nib_g, nib_l, nib_e;

    // Nibble selected by the current index, fed to the shared comparator.
    always_comb begin
        nib_a = 4'h0;
        nib_b = 4'h0;
        for (int i = 0; i < N; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nib_a = ra_q[4*i +: 4];
                nib_b = rb_q[4*i +: 4];
            end
        end
    end

    comparador_4_bits u_cmp (
        .a (nib_a),
        .b (nib_b),
        .g (nib_g),
        .l (nib_l),
        .e (nib_e)
    );

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the values from before the edge, independent of block order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_COMPARE;
            end
            S_COMPARE: begin
                if (nib_g || nib_l || (nib_e && idx_q == '0)) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy = (state_q == S_COMPARE);
        done = (state_q == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ra_q  <= '0;
            rb_q  <= '0;
            idx_q <= '0;
            g_q   <= 1'b0;
            l_q   <= 1'b0;
            e_q   <= 1'b0;
        end else begin
            ra_q  <= ra_d;
            rb_q  <= rb_d;
            idx_q <= idx_d;
            g_q   <= g_d;
            l_q   <= l_d;
            e_q   <= e_d;
        end
    end

    // NOTE: every signal gets a hold default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        ra_d  = ra_q;
        rb_d  = rb_q;
        idx_d = idx_q;
        g_d   = g_q;
        l_d   = l_q;
        e_d   = e_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ra_d  = A;
                    rb_d  = B;
                    idx_d = IDX_W'(N - 1);
                    g_d   = 1'b0;
                    l_d   = 1'b0;
                    e_d   = 1'b0;
                end
            end
            S_COMPARE: begin
                if (nib_g) begin
                    g_d = 1'b1;
                end else if (nib_l) begin
                    l_d = 1'b1;
                end else if (nib_e && idx_q == '0) begin
                    e_d = 1'b1;
                end else begin
                    // Reaching here implies idx_q > 0, so the index never wraps.
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            default: begin
            end
        endcase
    end

    assign G = g_q;
    assign L = l_q;
    assign E = e_q;

endmodule

// File: tb/tb_comparador_serial_ctrl.sv
// Self-checking bench for comparador_serial_ctrl (WIDTH=16): directed scenarios
// plus randomized operands checked against an arithmetic reference model.

module tb_comparador_serial_ctrl;

    localparam int W = 16;
    localparam int N = W / 4;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic         G;
    logic         L;
    logic         E;

    int n_cmp = 0;
    int n_err = 0;

    comparador_serial_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .G     (G),
        .L     (L),
        .E     (E)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: result by plain unsigned arithmetic, k = first differing nibble from MSB.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output int k, output logic [2:0] gle);
        k   = N;
        gle = {a > b, a < b, a == b};
        for (int i = 0; i < N; i++) begin
            if (((a >> (4 * (N - 1 - i))) & 16'h000F) != ((b >> (4 * (N - 1 - i))) & 16'h000F)) begin
                k = i + 1;
                break;
            end
        end
    endfunction

    // Issues one operation from IDLE (called at a negedge); returns in the IDLE cycle after DONE.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold, input bit scramble,
                         output int busy_cnt, output int done_edge, output logic [2:0] gle,
                         output logic done_again);
        int j;
        A = a;
        B = b;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold) start = 1'b0;
        if (scramble) begin
            A = '1;
            B = '0;
        end
        busy_cnt  = 0;
        done_edge = -1;
        gle       = 3'b000;
        j         = 0;
        while (done_edge < 0 && j < N + 6) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_edge = j;
                gle = {G, L, E};
            end else begin
                @(negedge clk);
                j++;
            end
        end
        @(negedge clk);
        done_again = done;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        A = '0;
        B = '0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy, done, G, L, E} !== 5'b00000) begin
            n_err++;
            $display("FAIL reset_state: busy,done,G,L,E=%b expected 00000", {busy, done, G, L, E});
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_msb_early_exit();
        int bc, de;
        logic [2:0] gle;
        logic da;
        do_op(16'hF000, 16'h0FFF, 1'b0, 1'b0, bc, de, gle, da);
        n_cmp++;
        if ({bc, de, gle, da} !== {32'd1, 32'd1, 3'b100, 1'b0}) begin
            n_err++;
            $display("FAIL msb_exit: busy_cyc=%0d done_edge=%0d GLE=%b done_again=%b expected 1 1 100 0",
                     bc, de, gle, da);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, done, G, L, E} !== 5'b00100) begin
            n_err++;
            $display("FAIL result_hold: busy,done,G,L,E=%b expected 00100", {busy, done, G, L, E});
        end
    endtask

    task automatic test_full_equal();
        int bc, de;
        logic [2:0] gle;
        logic da;
        do_op(16'hA5A5, 16'hA5A5, 1'b0, 1'b0, bc, de, gle, da);
        n_cmp++;
        if ({bc, de, gle, da} !== {32'd4, 32'd4, 3'b001, 1'b0}) begin
            n_err++;
            $display("FAIL full_equal: busy_cyc=%0d done_edge=%0d GLE=%b done_again=%b expected 4 4 001 0",
                     bc, de, gle, da);
        end
    endtask

    task automatic test_lsb_decides();
        int bc, de;
        logic [2:0] gle;
        logic da;
        do_op(16'h1230, 16'h1231, 1'b0, 1'b1, bc, de, gle, da);
        n_cmp++;
        if ({bc, de, gle, da} !== {32'd4, 32'd4, 3'b010, 1'b0}) begin
            n_err++;
            $display("FAIL lsb_decides: busy_cyc=%0d done_edge=%0d GLE=%b done_again=%b expected 4 4 010 0",
                     bc, de, gle, da);
        end
    endtask

    task automatic test_ignored_start();
        int bc, de, cyc;
        logic [2:0] gle;
        logic da;
        do_op(16'h0100, 16'h0200, 1'b1, 1'b0, bc, de, gle, da);
        n_cmp++;
        if ({bc, de, gle, da} !== {32'd2, 32'd2, 3'b010, 1'b0}) begin
            n_err++;
            $display("FAIL ignored_start_op: busy_cyc=%0d done_edge=%0d GLE=%b done_again=%b expected 2 2 010 0",
                     bc, de, gle, da);
        end
        // Cycle after edge 3: back in IDLE, start held through DONE must not have been taken.
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL start_in_done: busy=%b expected 0", busy);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL issue_interval: busy=%b at cycle after edge 4, expected 1", busy);
        end
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < N + 6) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if ({cyc, done, G, L, E} !== {32'd2, 1'b1, 3'b010}) begin
            n_err++;
            $display("FAIL second_op: cycles=%0d done=%b GLE=%b expected 2 1 010", cyc, done, {G, L, E});
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        int bc, de, seen;
        logic [2:0] gle;
        logic da;
        A = 16'h1234;
        B = 16'h1234;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid_pre: busy=%b expected 1", busy);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({busy, done, G, L, E} !== 5'b00000) begin
            n_err++;
            $display("FAIL reset_mid: busy,done,G,L,E=%b expected 00000", {busy, done, G, L, E});
        end
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL reset_no_done: busy/done seen in %0d cycles expected 0", seen);
        end
        do_op(16'h1234, 16'h1235, 1'b0, 1'b0, bc, de, gle, da);
        n_cmp++;
        if ({bc, de, gle, da} !== {32'd4, 32'd4, 3'b010, 1'b0}) begin
            n_err++;
            $display("FAIL after_reset_op: busy_cyc=%0d done_edge=%0d GLE=%b done_again=%b expected 4 4 010 0",
                     bc, de, gle, da);
        end
    endtask

    // Back-to-back random operations: each issue happens in the IDLE cycle right after DONE.
    task automatic test_random(input int count);
        int bc, de, k, pos;
        logic [2:0] gle, exp_gle;
        logic da;
        logic [W-1:0] a, b;
        for (int t = 0; t < count; t++) begin
            b   = W'($urandom);
            a   = b;
            pos = $urandom_range(0, N);
            if (pos < N) begin
                a[4*pos +: 4] = b[4*pos +: 4] ^ 4'($urandom_range(1, 15));
                for (int i = 0; i < pos; i++) a[4*i +: 4] = 4'($urandom);
            end
            model(a, b, k, exp_gle);
            do_op(a, b, 1'b0, 1'b0, bc, de, gle, da);
            n_cmp++;
            if ({bc, de, gle, da} !== {k, k, exp_gle, 1'b0}) begin
                n_err++;
                $display("FAIL random A=%h B=%h: busy_cyc=%0d done_edge=%0d GLE=%b done_again=%b expected %0d %0d %b 0",
                         a, b, bc, de, gle, da, k, k, exp_gle);
            end
        end
    endtask

    initial begin
        test_reset();
        test_msb_early_exit();
        test_full_equal();
        test_lsb_decides();
        test_ignored_start();
        test_reset_mid_op();
        test_random(60);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/comparador_serial_ctrl.md
Name: comparador_serial_ctrl

Overview:
- Sequential magnitude comparator for wide unsigned operands.
- Reuses one comparador_4_bits instance, time-shared across nibbles, instead of one comparator per nibble.
- Nibbles are compared MSB-first. The comparison stops early at the first unequal nibble.
- Exposes a start/busy/done handshake, so a higher-level datapath (sorter, max-finder) can issue comparisons back to back.

Parameters:
- WIDTH, 16, operand width in bits. Must be a multiple of 4 and at least 8.
- N = WIDTH/4 (local, not overridable): number of nibbles.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a comparison. Sampled only in IDLE.
- A  input  WIDTH  operand A, unsigned. Sampled on the accepting edge only.
- B  input  WIDTH  operand B, unsigned. Sampled on the accepting edge only.
- busy  output  1  high while a comparison is in progress (state COMPARE).
- done  output  1  one-cycle pulse: result valid and newly produced.
- G  output  1  A > B. Registered.
- L  output  1  A < B. Registered.
- E  output  1  A == B. Registered.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous, active-high.
- Reset values: state=IDLE; busy, done, G, L, E = 0; operand registers = 0; nibble index = 0. Reset asserted mid-comparison aborts the operation immediately. No done pulse is produced for the aborted operation.
- States: IDLE, COMPARE, DONE.
- IDLE:
  - busy=0, done=0.
  - On an edge with start=1: capture A into ra and B into rb; set index=N-1; clear G, L, E to 0; go to COMPARE.
  - start=0: stay in IDLE.
- COMPARE:
  - busy=1.
  - The comparador_4_bits inputs are ra[4*index+3 : 4*index] and rb[4*index+3 : 4*index], selected combinationally.
  - On each edge:
    - Nibble G=1: G<=1; go to DONE.
    - Nibble L=1: L<=1; go to DONE.
    - Nibble E=1 and index==0: E<=1; go to DONE.
    - Otherwise: index<=index-1; stay in COMPARE.
- DONE:
  - busy=0, done=1 for exactly this cycle.
  - Next edge: go to IDLE unconditionally.
- Latency:
  - Let k be the position of the first unequal nibble counted from the MSB (1..N), or k=N if the operands are equal.
  - Accepting edge = edge 0. The final compare happens on edge k. done is high in the cycle after edge k.
  - Minimum 1 compare cycle; maximum N.
  - Issue-to-issue interval is k+2 cycles.
- Result hold: G, L, E hold their values after DONE until the next accepting edge. Exactly one of them is 1 after any completed comparison.
- start handling:
  - start while in COMPARE or DONE is ignored, not queued.
  - A and B changing after the accepting edge have no effect on the current comparison.
- The index counter never wraps. Exit at index==0 is mandatory.
- Arithmetic: unsigned only. No signed mode.

Test Plan (WIDTH=16, N=4):
- Reset mid-operation: start with A=16'h1234, B=16'h1234; assert reset on the 2nd COMPARE cycle -> busy, done, G, L, E = 0 immediately. No done pulse follows; the next start works normally.
- MSB early exit: A=16'hF000, B=16'h0FFF, start -> G=1, L=0, E=0; done 1 cycle after edge 1; busy high for exactly 1 cycle.
- Full-length equal: A=B=16'hA5A5 -> E=1, G=0, L=0; busy high for 4 cycles; done after edge 4.
- LSB decides: A=16'h1230, B=16'h1231 -> L=1 after 4 compare cycles. Then change A and B mid-operation to 16'hFFFF/16'h0000 -> result still L=1.
- Ignored start: hold start=1 continuously with A=16'h0100, B=16'h0200 -> L=1 after 2 compare cycles. The next operation is accepted only in IDLE; issue-to-issue interval is 4 cycles.
